// File: rtl/mc_mips_core.sv
// Multi-cycle MIPS core: a single shared ALU sequenced by a FETCH/DECODE/EXEC/MEM/WB
// state machine, with internal register file and data memory, halt detection and retire counter.
module mc_mips_core #(
   parameter int IMEM_BYTES = 256,
   parameter int DMEM_WORDS = 64,
   parameter int NUM_REGS   = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IMEM_BYTES-1:0][7:0] instruction_mem,
   output logic [31:0]                alu_result,
   output logic [31:0]                pc,
   output logic [2:0]                 state,
   output logic                       halted,
   output logic [31:0]                retired
);
   localparam int IA = $clog2(IMEM_BYTES);
   localparam int DA = $clog2(DMEM_WORDS);
   localparam int RA = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES - 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   logic [31:0] ir;
   logic [31:0] reg_a;
   logic [31:0] reg_b;
   logic [31:0] mdr;
   logic [31:0] regs [NUM_REGS];
   logic [31:0] dmem [DMEM_WORDS];

   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [31:0]   imm_sext;
   logic [31:0]   alu_out;
   logic [31:0]   fetch_word;
   logic [31:0]   jump_target;
   logic [31:0]   branch_target;
   logic [31:0]   wb_data;
   logic [IA-1:0] fetch_idx;
   logic [DA-1:0] dmem_idx;
   logic [4:0]    wb_dest;
   logic          wb_ok;
   logic          known_op;

   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign funct    = ir[5:0];
   assign imm_sext = {{16{ir[15]}}, ir[15:0]};

   // Byte indices wrap naturally because fetch_idx is only IA bits wide
   assign fetch_idx  = pc[IA-1:0];
   assign fetch_word = {instruction_mem[fetch_idx],
                        instruction_mem[fetch_idx + IA'(1)],
                        instruction_mem[fetch_idx + IA'(2)],
                        instruction_mem[fetch_idx + IA'(3)]};

   assign jump_target   = {pc[31:28], ir[25:0], 2'b00} & PC_MASK;
   assign branch_target = (pc + {imm_sext[29:0], 2'b00}) & PC_MASK;
   assign dmem_idx      = alu_result[DA+1:2];
   assign wb_dest       = (opcode == OP_RTYPE) ? rd : rt;
   assign wb_data       = (opcode == OP_LW) ? mdr : alu_result;
   assign wb_ok         = (wb_dest != 5'd0) && (int'(wb_dest) < NUM_REGS);
   assign halted        = (state == S_HALT);

   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 5'd0 || int'(idx) >= NUM_REGS) return 32'd0;
      return regs[idx[RA-1:0]];
   endfunction

   always_comb begin
      case (opcode)
         OP_RTYPE, OP_BEQ, OP_ADDI, OP_LW, OP_SW: known_op = 1'b1;
         default:                                 known_op = 1'b0;
      endcase
   end

   always_comb begin
      alu_out = 32'd0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  alu_out = reg_a + reg_b;
               FN_SUB:  alu_out = reg_a - reg_b;
               FN_AND:  alu_out = reg_a & reg_b;
               FN_OR:   alu_out = reg_a | reg_b;
               FN_SLT:  alu_out = {31'd0, $signed(reg_a) < $signed(reg_b)};
               default: alu_out = 32'd0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_out = reg_a + imm_sext;
         OP_BEQ:                alu_out = reg_a - reg_b;
         default:               alu_out = 32'd0;
      endcase
   end

   // Every path that returns to FETCH bumps retired; HALT never does
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_FETCH;
         pc         <= 32'd0;
         alu_result <= 32'd0;
         retired    <= 32'd0;
         ir         <= 32'd0;
         reg_a      <= 32'd0;
         reg_b      <= 32'd0;
         mdr        <= 32'd0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
         for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'd0;
      end else begin
         case (state)
            S_FETCH: begin
               ir    <= fetch_word;
               pc    <= (pc + 32'd4) & PC_MASK;
               state <= S_DECODE;
            end
            S_DECODE: begin
               reg_a <= read_reg(rs);
               reg_b <= read_reg(rt);
               if (opcode == OP_HALT) begin
                  state <= S_HALT;
               end else if (opcode == OP_J) begin
                  pc      <= jump_target;
                  retired <= retired + 32'd1;
                  state   <= S_FETCH;
               end else if (!known_op) begin
                  retired <= retired + 32'd1;
                  state   <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               alu_result <= alu_out;
               if (opcode == OP_BEQ) begin
                  if (alu_out == 32'd0) pc <= branch_target;
                  retired <= retired + 32'd1;
                  state   <= S_FETCH;
               end else if (opcode == OP_LW || opcode == OP_SW) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (opcode == OP_LW) begin
                  mdr   <= dmem[dmem_idx];
                  state <= S_WB;
               end else begin
                  dmem[dmem_idx] <= reg_b;
                  retired        <= retired + 32'd1;
                  state          <= S_FETCH;
               end
            end
            S_WB: begin
               if (wb_ok) regs[wb_dest[RA-1:0]] <= wb_data;
               retired <= retired + 32'd1;
               state   <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_mips_core.sv
// Directed bench for mc_mips_core: small programs per feature, EXEC results checked
// through a scoreboard of expected alu_result values, plus pc/retired/state checks.
module tb_mc_mips_core;
   localparam int IMEM_BYTES = 256;
   localparam int DMEM_WORDS = 64;
   localparam int NUM_REGS   = 8;

   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [IMEM_BYTES-1:0][7:0] imem;
   logic [31:0]                alu_result;
   logic [31:0]                pc;
   logic [2:0]                 state;
   logic                       halted;
   logic [31:0]                retired;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   string       sb_tag[$];
   logic [31:0] sb_val[$];
   logic [2:0]  trace[$];

   mc_mips_core #(
      .IMEM_BYTES(IMEM_BYTES),
      .DMEM_WORDS(DMEM_WORDS),
      .NUM_REGS  (NUM_REGS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .instruction_mem(imem),
      .alu_result     (alu_result),
      .pc             (pc),
      .state          (state),
      .halted         (halted),
      .retired        (retired)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] target);
      return {OP_J, target};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic load_word(input int addr, input logic [31:0] w);
      imem[addr]     = w[31:24];
      imem[addr + 1] = w[23:16];
      imem[addr + 2] = w[15:8];
      imem[addr + 3] = w[7:0];
   endtask

   task automatic push_exp(input string tag, input logic [31:0] value);
      sb_tag.push_back(tag);
      sb_val.push_back(value);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb_tag.delete();
      sb_val.delete();
      trace.delete();
      cyc = 0;
   endtask

   // One clock; an edge taken from EXEC produces a fresh alu_result to score
   task automatic step();
      logic [2:0] prev;
      prev = state;
      trace.push_back(prev);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (prev == 3'd2) begin
         if (sb_tag.size() == 0) begin
            check_output("sb_underflow", alu_result, 32'hDEAD_BEEF);
         end else begin
            check_output(sb_tag.pop_front(), alu_result, sb_val.pop_front());
         end
      end
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_halt(input int budget);
      while (halted !== 1'b1 && cyc < budget) step();
      check_output("halt_reached", 32'(halted), 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      imem  = '0;

      // Arithmetic program, 18 cycles to HALT
      load_word(0,  enc_i(OP_ADDI, 0, 1, 16'd5));
      load_word(4,  enc_i(OP_ADDI, 0, 2, 16'hFFFD));
      load_word(8,  enc_r(1, 2, 3, FN_ADD));
      load_word(12, enc_r(2, 1, 4, FN_SLT));
      load_word(16, HALT_WORD);
      apply_reset();
      check_output("rst_state", 32'(state), 32'd0);
      check_output("rst_pc", pc, 32'd0);
      check_output("rst_alu", alu_result, 32'd0);
      check_output("rst_retired", retired, 32'd0);
      check_output("rst_halted", 32'(halted), 32'd0);
      push_exp("addi_r1", 32'd5);
      push_exp("addi_r2", 32'hFFFF_FFFD);
      push_exp("add_r3", 32'd2);
      push_exp("slt_r4", 32'd1);
      run_until_halt(100);
      check_output("arith_cycles", 32'(cyc), 32'd18);
      check_output("arith_retired", retired, 32'd4);
      check_output("arith_pc", pc, 32'h14);
      check_output("arith_state", 32'(state), 32'd5);
      check_output("arith_sb_empty", 32'(sb_tag.size()), 32'd0);
      step_n(3);
      check_output("halt_pc_hold", pc, 32'h14);
      check_output("halt_retired_hold", retired, 32'd4);

      // Memory program: store, load back, probe the loaded register
      imem = '0;
      load_word(0,  enc_i(OP_ADDI, 0, 1, 16'h0011));
      load_word(4,  enc_i(OP_SW, 0, 1, 16'd8));
      load_word(8,  enc_i(OP_LW, 0, 5, 16'd8));
      load_word(12, enc_r(5, 0, 6, FN_OR));
      load_word(16, HALT_WORD);
      apply_reset();
      push_exp("mem_addi", 32'h11);
      push_exp("mem_sw_addr", 32'd8);
      push_exp("mem_lw_addr", 32'd8);
      push_exp("mem_lw_probe", 32'h11);
      run_until_halt(100);
      check_output("mem_cycles", 32'(cyc), 32'd19);
      check_output("mem_retired", retired, 32'd4);
      check_output("mem_pc", pc, 32'h14);
      for (int k = 0; k < 5; k++) check_output($sformatf("lw_state_%0d", k), 32'(trace[8 + k]), 32'(k));
      check_output("mem_sb_empty", 32'(sb_tag.size()), 32'd0);

      // Branch skips the addi at 0x04, jump lands on HALT at 0x40
      imem = '0;
      load_word(0,    enc_i(OP_BEQ, 0, 0, 16'd1));
      load_word(4,    enc_i(OP_ADDI, 0, 1, 16'd9));
      load_word(8,    enc_j(26'h10));
      load_word(8'h40, HALT_WORD);
      apply_reset();
      push_exp("beq_sub", 32'd0);
      run_until_halt(100);
      check_output("br_pc", pc, 32'h44);
      check_output("br_retired", retired, 32'd2);
      check_output("br_sb_empty", 32'(sb_tag.size()), 32'd0);

      // Register index boundaries with NUM_REGS=8
      imem = '0;
      load_word(0,  enc_i(OP_ADDI, 0, 9, 16'd7));
      load_word(4,  enc_r(9, 0, 1, FN_ADD));
      load_word(8,  enc_i(OP_ADDI, 0, 0, 16'd1));
      load_word(12, enc_r(0, 1, 2, FN_OR));
      load_word(16, HALT_WORD);
      apply_reset();
      push_exp("bnd_addi_r9", 32'd7);
      push_exp("bnd_read_r9", 32'd0);
      push_exp("bnd_addi_r0", 32'd1);
      push_exp("bnd_r0_r1_zero", 32'd0);
      run_until_halt(100);
      check_output("bnd_retired", retired, 32'd4);
      check_output("bnd_sb_empty", 32'(sb_tag.size()), 32'd0);

      // pc wraps from 0xFC back to 0x00
      imem = '0;
      load_word(0,     enc_j(26'h3F));
      load_word(8'hFC, enc_i(OP_ADDI, 0, 3, 16'h0033));
      apply_reset();
      push_exp("wrap_addi", 32'h33);
      step_n(2);
      check_output("wrap_pc_fc", pc, 32'hFC);
      step();
      check_output("wrap_pc_zero", pc, 32'h00);
      step_n(3);
      check_output("wrap_retired", retired, 32'd2);
      check_output("wrap_sb_empty", 32'(sb_tag.size()), 32'd0);

      // Reset asserted while sw sits in MEM
      imem = '0;
      load_word(0, enc_i(OP_ADDI, 0, 1, 16'h0055));
      load_word(4, enc_i(OP_SW, 0, 1, 16'd12));
      load_word(8, HALT_WORD);
      apply_reset();
      push_exp("rst_addi", 32'h55);
      push_exp("rst_sw_addr", 32'd12);
      step_n(7);
      check_output("rst_in_mem", 32'(state), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check_output("arst_state", 32'(state), 32'd0);
      check_output("arst_pc", pc, 32'd0);
      check_output("arst_alu", alu_result, 32'd0);
      check_output("arst_retired", retired, 32'd0);
      check_output("arst_halted", 32'(halted), 32'd0);
      check_output("arst_sb_empty", 32'(sb_tag.size()), 32'd0);
      imem = '0;
      load_word(0, enc_i(OP_LW, 0, 2, 16'd12));
      load_word(4, enc_r(2, 0, 3, FN_OR));
      load_word(8, HALT_WORD);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      push_exp("post_rst_lw_addr", 32'd12);
      push_exp("post_rst_dmem", 32'd0);
      step();
      check_output("first_fetch_state", 32'(state), 32'd1);
      check_output("first_fetch_pc", pc, 32'd4);
      run_until_halt(100);
      check_output("post_rst_retired", retired, 32'd2);
      check_output("post_rst_sb_empty", 32'(sb_tag.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
